// File: rtl/fetch_predecoder_pkg.sv
// rtl/fetch_predecoder_pkg.sv - opcode constants, control kinds and FSM states for the predecoder
package fetch_predecoder_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_REGIMM  = 6'b000001;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_BGTZ    = 6'b000111;
  localparam logic [5:0] FN_JR      = 6'b001000;

  typedef enum logic [2:0] {NONE, BR, J, JAL, JR} ctrl_kind_e;
  typedef enum logic {SCAN, WAIT_DS} state_e;

  function automatic ctrl_kind_e classify(input logic [31:0] inst);
    ctrl_kind_e kind;
    kind = NONE;
    case (inst[31:26])
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: kind = BR;
      OP_J:       kind = J;
      OP_JAL:     kind = JAL;
      OP_SPECIAL: kind = (inst[5:0] == FN_JR) ? JR : NONE;
      default:    kind = NONE;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/fetch_predecoder_if.sv
// rtl/fetch_predecoder_if.sv - fetch-line input and pre-decode bundle output handshakes
interface fetch_predecoder_if #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 32,
  parameter int FETCH_WIDTH   = 4,
  parameter int SLOT_BITS     = $clog2(FETCH_WIDTH)
);
  logic                              i_valid;
  logic                              o_ready;
  logic [ADDRESS_WIDTH-1:0]          i_pc;
  logic [FETCH_WIDTH*DATA_WIDTH-1:0] i_line;
  logic                              o_valid;
  logic                              i_ready;
  logic [FETCH_WIDTH-1:0]            o_slot_valid;
  logic                              o_isbranch;
  logic                              o_j_inst;
  logic                              o_jal_inst;
  logic                              o_jr_inst;
  logic [SLOT_BITS-1:0]              o_ctrl_slot;
  logic [ADDRESS_WIDTH-1:0]          o_branch_address;
  logic [ADDRESS_WIDTH-1:0]          o_branch_target;
  logic                              o_delay_slot;

  modport slave (
    input  i_valid, i_pc, i_line, i_ready,
    output o_ready, o_valid, o_slot_valid, o_isbranch, o_j_inst, o_jal_inst, o_jr_inst,
           o_ctrl_slot, o_branch_address, o_branch_target, o_delay_slot
  );

  modport master (
    output i_valid, i_pc, i_line, i_ready,
    input  o_ready, o_valid, o_slot_valid, o_isbranch, o_j_inst, o_jal_inst, o_jr_inst,
           o_ctrl_slot, o_branch_address, o_branch_target, o_delay_slot
  );
endinterface

// File: rtl/fetch_predecoder_slot.sv
// rtl/fetch_predecoder_slot.sv - combinational classifier and target calculator for one slot
module predecode_slot
  import fetch_predecoder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22
) (
  input  logic [31:0]              inst_i,
  input  logic [ADDRESS_WIDTH-1:0] slot_pc_i,
  output ctrl_kind_e               kind_o,
  output logic [ADDRESS_WIDTH-1:0] target_o
);
  logic [ADDRESS_WIDTH-1:0] imm_sext;
  logic                     unused_inst;

  assign kind_o      = classify(inst_i);
  assign imm_sext    = ADDRESS_WIDTH'($signed(inst_i[15:0]));
  assign unused_inst = ^inst_i;

  // jr targets come from the jump stack, so they report zero here
  always_comb begin
    target_o = '0;
    case (kind_o)
      BR:      target_o = slot_pc_i + ADDRESS_WIDTH'(1) + imm_sext;
      J, JAL:  target_o = inst_i[ADDRESS_WIDTH-1:0];
      default: target_o = '0;
    endcase
  end
endmodule

// File: rtl/fetch_predecoder.sv
// rtl/fetch_predecoder.sv - registered fetch-line pre-decode with delay-slot tracking
module fetch_predecoder
  import fetch_predecoder_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 22,
  parameter int DATA_WIDTH    = 32,
  parameter int FETCH_WIDTH   = 4,
  parameter int SLOT_BITS     = $clog2(FETCH_WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_flush,
  fetch_predecoder_if.slave  bus
);
  localparam int AW = ADDRESS_WIDTH;

  ctrl_kind_e           kind  [FETCH_WIDTH];
  logic [AW-1:0]        tgt   [FETCH_WIDTH];
  logic [AW-1:0]        spc   [FETCH_WIDTH];

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_slot
    assign spc[k] = {bus.i_pc[AW-1:SLOT_BITS], SLOT_BITS'(k)};
    predecode_slot #(.ADDRESS_WIDTH(AW)) u_slot (
      .inst_i    (bus.i_line[k*DATA_WIDTH +: 32]),
      .slot_pc_i (spc[k]),
      .kind_o    (kind[k]),
      .target_o  (tgt[k])
    );
  end

  state_e                 state_q;
  logic                   valid_q;
  logic [FETCH_WIDTH-1:0] slot_valid_q, slot_valid_d;
  logic [3:0]             flags_q, flags_d;
  logic [SLOT_BITS-1:0]   ctrl_slot_q, ctrl_slot_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [AW-1:0]          tgt_q, tgt_d;
  logic                   ds_q, ds_d;
  logic [SLOT_BITS-1:0]   off;
  logic                   found;
  logic                   accept;

  assign bus.o_ready = !valid_q || bus.i_ready;
  assign accept      = bus.i_valid && bus.o_ready;

  // In WAIT_DS the first wanted slot is the previous line's delay slot
  always_comb begin
    off          = bus.i_pc[SLOT_BITS-1:0];
    slot_valid_d = '0;
    found        = 1'b0;
    ctrl_slot_d  = '0;
    flags_d      = 4'b0000;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slot_valid_d[k] = (SLOT_BITS'(k) >= off) &&
                        !((state_q == WAIT_DS) && (SLOT_BITS'(k) == off));
    end
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (!found && slot_valid_d[k] && (kind[k] != NONE)) begin
        found       = 1'b1;
        ctrl_slot_d = SLOT_BITS'(k);
        flags_d     = {kind[k] == BR, kind[k] == J, kind[k] == JAL, kind[k] == JR};
      end
    end
    addr_d = found ? spc[ctrl_slot_d] : bus.i_pc;
    tgt_d  = found ? tgt[ctrl_slot_d] : '0;
    ds_d   = found && (ctrl_slot_d == SLOT_BITS'(FETCH_WIDTH - 1));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= SCAN;
      valid_q      <= 1'b0;
      slot_valid_q <= '0;
      flags_q      <= '0;
      ctrl_slot_q  <= '0;
      addr_q       <= '0;
      tgt_q        <= '0;
      ds_q         <= 1'b0;
    end else if (i_flush) begin
      state_q <= SCAN;
      valid_q <= 1'b0;
    end else if (accept) begin
      state_q      <= ds_d ? WAIT_DS : SCAN;
      valid_q      <= 1'b1;
      slot_valid_q <= slot_valid_d;
      flags_q      <= flags_d;
      ctrl_slot_q  <= ctrl_slot_d;
      addr_q       <= addr_d;
      tgt_q        <= tgt_d;
      ds_q         <= ds_d;
    end else if (bus.i_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.o_valid          = valid_q;
  assign bus.o_slot_valid     = slot_valid_q;
  assign bus.o_isbranch       = flags_q[3];
  assign bus.o_j_inst         = flags_q[2];
  assign bus.o_jal_inst       = flags_q[1];
  assign bus.o_jr_inst        = flags_q[0];
  assign bus.o_ctrl_slot      = ctrl_slot_q;
  assign bus.o_branch_address = addr_q;
  assign bus.o_branch_target  = tgt_q;
  assign bus.o_delay_slot     = ds_q;
endmodule
